led7seg_scan: RTL and testbench

Parametrised multiplexed driver for an N-digit common-cathode 7-segment display. Accepts a packed BCD/hex value, buffers it tear-free at frame boundaries, and time-multiplexes the digits with a programmable refresh prescaler and an anti-ghosting dead time. Optional hex glyphs and leading-zero blanking are included. Sits between the datapath producing display values and the board's segment/digit pins, replacing per-digit combinational decoders.

---
 rtl/led7_pkg.sv | 38 +++
 rtl/led7_hex_dec.sv | 35 +++
 rtl/led7seg_scan.sv | 140 ++++++++++++++
 tb/tb_led7seg_scan.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/led7_pkg.sv
// Purpose: shared segment encodings and bit ordering for the 7-segment display driver.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package led7_pkg;

    // Bit position of each segment inside a segment word: {g,f,e,d,c,b,a}.
    typedef enum int {
        SB_A = 0,
        SB_B = 1,
        SB_C = 2,
        SB_D = 3,
        SB_E = 4,
        SB_F = 5,
        SB_G = 6
    } seg_bit_e;

    typedef logic [SB_G:SB_A] seg_t;

    localparam seg_t SEG_0   = 7'b0111111;
    localparam seg_t SEG_1   = 7'b0000110;
    localparam seg_t SEG_2   = 7'b1011011;
    localparam seg_t SEG_3   = 7'b1001111;
    localparam seg_t SEG_4   = 7'b1100110;
    localparam seg_t SEG_5   = 7'b1101101;
    localparam seg_t SEG_6   = 7'b1111101;
    localparam seg_t SEG_7   = 7'b0000111;
    localparam seg_t SEG_8   = 7'b1111111;
    localparam seg_t SEG_9   = 7'b1101111;
    localparam seg_t SEG_A   = 7'b1110111;
    localparam seg_t SEG_B   = 7'b1111100;
    localparam seg_t SEG_C   = 7'b0111001;
    localparam seg_t SEG_D   = 7'b1011110;
    localparam seg_t SEG_E   = 7'b1111001;
    localparam seg_t SEG_F   = 7'b1110001;
    localparam seg_t SEG_ALL = 7'b1111111;
    localparam seg_t SEG_OFF = 7'b0000000;

endpackage

// File: rtl/led7_hex_dec.sv
// Purpose: 4-bit code to active-high segment glyph decoder.
// Latency: purely combinational.
// Backpressure: none.
module led7_hex_dec
    import led7_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       hex_en_i,
    output seg_t       seg_o
);

    // Decimal glyphs always; codes 10..15 light every segment unless hex glyphs are enabled.
    always_comb begin
        seg_o = SEG_ALL;
        case (code_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA:    seg_o = hex_en_i ? SEG_A : SEG_ALL;
            4'hB:    seg_o = hex_en_i ? SEG_B : SEG_ALL;
            4'hC:    seg_o = hex_en_i ? SEG_C : SEG_ALL;
            4'hD:    seg_o = hex_en_i ? SEG_D : SEG_ALL;
            4'hE:    seg_o = hex_en_i ? SEG_E : SEG_ALL;
            default: seg_o = hex_en_i ? SEG_F : SEG_ALL;
        endcase
    end

endmodule

// File: rtl/led7seg_scan.sv
// Purpose: multiplexed N-digit common-cathode 7-segment driver with tear-free frame buffering.
// Latency: outputs registered one cycle after cnt/idx/display; loads become visible at the next frame.
// Backpressure: none; load is a strobe that is always accepted (last load in a frame wins).
module led7seg_scan
    import led7_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 50000,
    parameter int DEAD_CYC = 4,
    parameter bit HEX_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   dig_en,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = $clog2(N_DIGITS);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] pend_dig_q, pend_dig_d, disp_dig_q, disp_dig_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    seg_t                  seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   dig_en_q, dig_en_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick, wrap, dead;
    logic [N_DIGITS-1:0]   blank_mask;
    logic [3:0]            cur_code;
    logic                  cur_dp, cur_blank;
    seg_t                  dec_seg;

    assign tick = (cnt_q == CNT_W'(PRESCALE - 1));
    assign wrap = tick && (idx_q == IDX_W'(N_DIGITS - 1));
    assign dead = (cnt_q < CNT_W'(DEAD_CYC));

    // Slot timing: prescaler and digit index, plus display swap only at frame wrap.
    always_comb begin
        cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        pend_dig_d   = load ? digits_in : pend_dig_q;
        pend_dp_d    = load ? dp_in     : pend_dp_q;
        disp_dig_d   = disp_dig_q;
        disp_dp_d    = disp_dp_q;
        // A load landing on the wrap tick bypasses pending so it is not a frame late.
        if (wrap) begin
            disp_dig_d = load ? digits_in : pend_dig_q;
            disp_dp_d  = load ? dp_in     : pend_dp_q;
        end
        frame_done_d = wrap;
    end

    // Leading-zero mask: digit i blanks while every nibble from the top down to i is zero.
    always_comb begin
        logic lz_run;
        lz_run     = blank_lz;
        blank_mask = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            lz_run        = lz_run & (disp_dig_q[4*i +: 4] == 4'h0);
            blank_mask[i] = lz_run;
        end
    end

    // Select the nibble, dp and blank flag of the digit owning the current slot.
    always_comb begin
        cur_code  = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_code  = disp_dig_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                cur_blank = blank_mask[i];
            end
        end
    end

    led7_hex_dec u_dec (
        .code_i   (cur_code),
        .hex_en_i (HEX_EN),
        .seg_o    (dec_seg)
    );

    // Pin values: everything dark during dead time, otherwise the selected digit.
    always_comb begin
        seg_d    = SEG_OFF;
        dp_d     = 1'b0;
        dig_en_d = '0;
        if (!dead) begin
            dig_en_d = N_DIGITS'(1) << idx_q;
            seg_d    = cur_blank ? SEG_OFF : dec_seg;
            dp_d     = cur_dp;
        end
    end

    // State and output registers; reset clears buffers so a pending load is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_dig_q   <= '0;
            pend_dp_q    <= '0;
            disp_dig_q   <= '0;
            disp_dp_q    <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b0;
            dig_en_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            disp_dig_q   <= disp_dig_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led7seg_scan.sv
// Purpose: scoreboard bench for led7seg_scan (N_DIGITS=4, PRESCALE=8, DEAD_CYC=2), hex and non-hex builds.
// Latency: expected per-slot glyphs are queued per frame and popped at each slot's first lit cycle.
// Backpressure: none; stimulus waits on frame_done and dig_en with bounded cycle budgets.
module tb_led7seg_scan;

    localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011, S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110, S5 = 7'b1101101, S6 = 7'b1111101, S7 = 7'b0000111;
    localparam logic [6:0] S8 = 7'b1111111, S9 = 7'b1101111;
    localparam logic [6:0] SA = 7'b1110111, SB = 7'b1111100, SC = 7'b0111001, SD = 7'b1011110;
    localparam logic [6:0] SALL = 7'b1111111, SOFF = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [6:0]  seg, seg_nh;
    logic        dp, dp_nh, frame_done, frame_done_nh;
    logic [3:0]  dig_en, dig_en_nh;

    always #5 clk = ~clk;

    led7seg_scan #(.N_DIGITS(4), .PRESCALE(8), .DEAD_CYC(2), .HEX_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .seg(seg), .dp(dp), .dig_en(dig_en), .frame_done(frame_done)
    );

    led7seg_scan #(.N_DIGITS(4), .PRESCALE(8), .DEAD_CYC(2), .HEX_EN(1'b0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .blank_lz(blank_lz), .seg(seg_nh), .dp(dp_nh), .dig_en(dig_en_nh), .frame_done(frame_done_nh)
    );

    typedef struct {
        logic [3:0] en;
        logic [6:0] seg;
        logic       dp;
        logic [6:0] seg_nh;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [3:0] prev_en = 4'h0;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_slot(input logic [3:0] en, input logic [6:0] s, input logic d, input logic [6:0] snh);
        exp_t e;
        e.en = en; e.seg = s; e.dp = d; e.seg_nh = snh;
        exp_q.push_back(e);
    endtask

    // Slots 0..3 in order; the non-hex build is expected to match for decimal content.
    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input logic [3:0] dpv);
        push_slot(4'b0001, s0, dpv[0], s0);
        push_slot(4'b0010, s1, dpv[1], s1);
        push_slot(4'b0100, s2, dpv[2], s2);
        push_slot(4'b1000, s3, dpv[3], s3);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dpv);
        digits_in = v;
        dp_in     = dpv;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 200);
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL frame_done wait: no pulse within 200 cycles, expected one every 32");
        end
    endtask

    task automatic wait_slot(input logic [3:0] en);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dig_en !== en && n < 200);
        if (dig_en !== en) begin
            checks++;
            errors++;
            $display("FAIL slot wait: dig_en=%b never reached %b within 200 cycles", dig_en, en);
        end
    endtask

    // Monitor: each slot's first lit cycle consumes one queued expectation.
    always @(negedge clk) begin
        if (prev_en == 4'h0 && dig_en != 4'h0 && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("slot dig_en", {28'h0, dig_en}, {28'h0, mon_e.en});
            check("slot seg", {25'h0, seg}, {25'h0, mon_e.seg});
            check("slot dp", {31'h0, dp}, {31'h0, mon_e.dp});
            check("slot seg nohex", {25'h0, seg_nh}, {25'h0, mon_e.seg_nh});
        end
        prev_en = dig_en;
    end

    initial begin
        // Reset state.
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset seg", {25'h0, seg}, 32'h0);
        check("reset dp", {31'h0, dp}, 32'h0);
        check("reset dig_en", {28'h0, dig_en}, 32'h0);
        check("reset frame_done", {31'h0, frame_done}, 32'h0);

        // First frame after release shows the cleared display.
        push_frame(S0, S0, S0, S0, 4'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("release dead time", {28'h0, dig_en}, 32'h0);
        @(negedge clk);
        check("release first dig_en", {28'h0, dig_en}, 32'h1);
        check("release first seg", {25'h0, seg}, {25'h0, S0});

        // Decode and digit order.
        do_load(16'h1234, 4'h0);
        wait_fd();
        push_frame(S4, S3, S2, S1, 4'h0);

        // Hex glyphs, and all-segments in the non-hex build.
        do_load(16'hABCD, 4'h0);
        wait_fd();
        push_slot(4'b0001, SD, 1'b0, SALL);
        push_slot(4'b0010, SC, 1'b0, SALL);
        push_slot(4'b0100, SB, 1'b0, SALL);
        push_slot(4'b1000, SA, 1'b0, SALL);

        // Leading-zero blanking; dp on a blanked digit still shows.
        blank_lz = 1'b1;
        do_load(16'h0070, 4'b0100);
        wait_fd();
        push_frame(S0, S7, SOFF, SOFF, 4'b0100);
        do_load(16'h0000, 4'h0);
        wait_fd();
        push_frame(S0, SOFF, SOFF, SOFF, 4'h0);

        // Tear-free: a load in slot 1 leaves the rest of the frame untouched.
        do_load(16'h1234, 4'h0);
        wait_fd();
        blank_lz = 1'b0;
        push_frame(S4, S3, S2, S1, 4'h0);
        wait_slot(4'b0010);
        do_load(16'h5555, 4'h0);
        wait_fd();
        push_frame(S5, S5, S5, S5, 4'h0);

        // Load exactly on the wrap tick (31 cycles after the frame_done cycle).
        repeat (31) @(negedge clk);
        do_load(16'h9876, 4'h0);
        check("frame_done after wrap load", {31'h0, frame_done}, 32'h1);
        push_frame(S6, S7, S8, S9, 4'h0);
        wait_fd();

        // Dead time, one-hot slots and frame period over three frames.
        for (int k = 0; k < 96; k++) begin
            int s;
            logic [3:0] en_x;
            s    = (k + 31) % 32;
            en_x = ((s % 8) < 2) ? 4'h0 : (4'h1 << (s / 8));
            check("slot timing {dig_en,frame_done}", {27'h0, dig_en, frame_done},
                  {27'h0, en_x, (k % 32) == 0});
            @(negedge clk);
        end

        // Asynchronous reset mid-slot drops outputs at once and loses the pending load.
        wait_slot(4'b0010);
        do_load(16'h8888, 4'h0);
        #2 rst_n = 1'b0;
        #1;
        check("async reset seg", {25'h0, seg}, 32'h0);
        check("async reset dp", {31'h0, dp}, 32'h0);
        check("async reset dig_en", {28'h0, dig_en}, 32'h0);
        check("async reset frame_done", {31'h0, frame_done}, 32'h0);
        push_frame(S0, S0, S0, S0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fd();
        push_frame(S0, S0, S0, S0, 4'h0);
        wait_fd();
        check("scoreboard drained", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
